// File: rtl/secuenciador_param.sv
// Multi-bank pattern sequencer: a byte-wide loader fills word banks, and a playback FSM
// streams one bank out word by word, once or looped.
module secuenciador_param #(
  parameter int unsigned       WIDTH     = 16,
  parameter int unsigned       DEPTH     = 32,
  parameter int unsigned       NBANKS    = 4,
  parameter logic [WIDTH-1:0]  IDLE_WORD = '0,
  localparam int unsigned      AW        = $clog2(DEPTH),
  localparam int unsigned      BW        = (NBANKS > 2) ? $clog2(NBANKS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [BW-1:0]    bank_sel,
  input  logic [AW-1:0]    len,
  input  logic             loop_en,
  input  logic             ld_start,
  input  logic [BW-1:0]    ld_bank,
  input  logic             wr,
  input  logic [7:0]       dato,
  output logic [WIDTH-1:0] theBeanConfig,
  output logic             busy,
  output logic             done,
  output logic             wr_err
);

  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic {StIdle, StRun} state_e;

  logic [WIDTH-1:0] mem_q [NBANKS][DEPTH];

  // Playback state
  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [BW-1:0]    bank_q, bank_d;
  logic [AW-1:0]    len_q, len_d;
  logic             loop_q, loop_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;
  logic             rd_en;
  logic [BW-1:0]    rd_bank;
  logic [AW-1:0]    rd_idx;

  // Loader state
  logic [CW-1:0]    cnt_q, cnt_d, cnt_eff;
  logic [AW:0]      ptr_q, ptr_d, ptr_eff;
  logic [BW-1:0]    lbank_q, lbank_d, lbank_eff;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic             mem_we;
  logic             wr_err_q, wr_err_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bank_d  = bank_q;
    len_d   = len_q;
    loop_d  = loop_q;
    out_d   = IDLE_WORD;
    done_d  = 1'b0;
    rd_en   = 1'b0;
    rd_bank = bank_q;
    rd_idx  = '0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StRun;
          bank_d  = bank_sel;
          len_d   = len;
          loop_d  = loop_en;
          idx_d   = '0;
          rd_en   = 1'b1;
          rd_bank = bank_sel;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (idx_q == len_q) begin
          if (loop_q) begin
            idx_d = '0;
            rd_en = 1'b1;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          idx_d  = idx_q + 1'b1;
          rd_en  = 1'b1;
          rd_idx = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (rd_en) out_d = mem_q[rd_bank][rd_idx];
  end

  // ld_start restarts the loader in the same cycle, so a concurrent wr lands as byte 0 of word 0.
  always_comb begin
    cnt_eff   = ld_start ? '0 : cnt_q;
    ptr_eff   = ld_start ? '0 : ptr_q;
    lbank_eff = ld_start ? ld_bank : lbank_q;
    cnt_d     = cnt_eff;
    ptr_d     = ptr_eff;
    lbank_d   = lbank_eff;
    asm_d     = asm_q;
    mem_we    = 1'b0;
    wr_err_d  = 1'b0;
    if (wr && !ptr_eff[AW]) begin
      asm_d[8*int'(cnt_eff) +: 8] = dato;
      if (cnt_eff == CW'(NB - 1)) begin
        cnt_d = '0;
        ptr_d = ptr_eff + 1'b1;
        if (state_q == StRun && lbank_eff == bank_q) wr_err_d = 1'b1;
        else                                         mem_we   = 1'b1;
      end else begin
        cnt_d = cnt_eff + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      bank_q   <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      out_q    <= IDLE_WORD;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      ptr_q    <= (AW + 1)'(DEPTH);
      lbank_q  <= '0;
      asm_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      bank_q   <= bank_d;
      len_q    <= len_d;
      loop_q   <= loop_d;
      out_q    <= out_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      lbank_q  <= lbank_d;
      asm_q    <= asm_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Pattern storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) mem_q[lbank_eff][ptr_eff[AW-1:0]] <= asm_d;
  end

  assign theBeanConfig = out_q;
  assign busy          = (state_q == StRun);
  assign done          = done_q;
  assign wr_err        = wr_err_q;

endmodule

// File: tb/tb_secuenciador_param.sv
// Randomised bench for secuenciador_param: a per-cycle behavioural model feeds an expectation
// queue that an independent negedge monitor drains against the DUT outputs.
module tb_secuenciador_param;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 32;
  localparam int NBANKS = 4;
  localparam int NB     = WIDTH / 8;
  localparam logic [WIDTH-1:0] IDLE_W = '0;

  logic             clk = 1'b0;
  logic             rst_n, start, abort, loop_en, ld_start, wr;
  logic [1:0]       bank_sel, ld_bank;
  logic [4:0]       len;
  logic [7:0]       dato;
  logic [WIDTH-1:0] dout;
  logic             busy, done, wr_err;

  secuenciador_param dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bank_sel(bank_sel), .len(len),
    .loop_en(loop_en), .ld_start(ld_start), .ld_bank(ld_bank), .wr(wr), .dato(dato),
    .theBeanConfig(dout), .busy(busy), .done(done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] word;
    logic             busy;
    logic             done;
    logic             err;
    string            tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  string phase = "reset";
  bit   finished = 0;

  // Behavioural model
  logic [WIDTH-1:0] m_mem [NBANKS][DEPTH];
  bit               m_play;
  int               m_bank, m_len, m_pos;
  bit               m_loop;
  byte unsigned     m_bytes[$];
  int               m_ptr, m_ldbank;

  task automatic model_edge();
    exp_t e;
    bit   do_wr = 0;
    int   wb = 0, wi = 0;
    logic [WIDTH-1:0] w = '0;
    e.tag = phase;
    e.err = 0;
    e.done = 0;
    if (!rst_n) begin
      m_play = 0;
      m_bytes.delete();
      m_ptr = DEPTH;
      m_ldbank = 0;
    end else begin
      if (ld_start) begin
        m_bytes.delete();
        m_ptr = 0;
        m_ldbank = int'(ld_bank);
      end
      if (wr && m_ptr < DEPTH) begin
        m_bytes.push_back(dato);
        if (m_bytes.size() == NB) begin
          for (int k = 0; k < NB; k++) w = w | (WIDTH'(m_bytes[k]) << (8 * k));
          if (m_play && m_ldbank == m_bank) e.err = 1;
          else begin
            do_wr = 1; wb = m_ldbank; wi = m_ptr;
          end
          m_ptr++;
          m_bytes.delete();
        end
      end
      if (!m_play) begin
        if (start && !abort) begin
          m_play = 1; m_bank = int'(bank_sel); m_len = int'(len); m_loop = loop_en; m_pos = 0;
        end
      end else if (abort) begin
        m_play = 0;
      end else if (m_pos == m_len) begin
        if (m_loop) m_pos = 0;
        else begin
          m_play = 0; e.done = 1;
        end
      end else begin
        m_pos++;
      end
    end
    e.busy = m_play;
    e.word = m_play ? m_mem[m_bank][m_pos] : IDLE_W;
    if (do_wr) m_mem[wb][wi] = w;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (dout !== e.word || busy !== e.busy || done !== e.done || wr_err !== e.err) begin
        n_fail++;
        $display("FAIL %s @%0t: got word=%h busy=%b done=%b wr_err=%b, want word=%h busy=%b done=%b wr_err=%b",
                 e.tag, $time, dout, busy, done, wr_err, e.word, e.busy, e.done, e.err);
      end
    end
  end

  initial begin
    #1_000_000;
    if (!finished) begin
      n_fail++;
      $display("FAIL timeout: stimulus did not complete in time (phase %s)", phase);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    start = 0; abort = 0; ld_start = 0; wr = 0;
  endtask

  task automatic put_byte(input logic [7:0] b, input bit first, input int bank);
    ld_start = first;
    ld_bank  = 2'(bank);
    wr       = 1;
    dato     = b;
    tick();
  endtask

  task automatic play(input int bank, input int l, input bit lp);
    start = 1; bank_sel = 2'(bank); len = 5'(l); loop_en = lp;
    tick();
  endtask

  initial begin
    rst_n = 0; start = 0; abort = 0; loop_en = 0; ld_start = 0; wr = 0;
    bank_sel = 0; ld_bank = 0; len = 0; dato = 0;
    m_play = 0; m_ptr = DEPTH; m_ldbank = 0; m_bank = 0; m_len = 0; m_pos = 0; m_loop = 0;
    repeat (3) tick();
    n_cmp++;
    if (dout !== IDLE_W || busy !== 1'b0 || done !== 1'b0 || wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state @%0t: word=%h busy=%b done=%b wr_err=%b", $time, dout, busy,
               done, wr_err);
    end
    rst_n = 1;
    tick();

    // ld_start with the first byte: word 0 of bank 0 is 0xCDAB, rest random
    phase = "load_b0";
    put_byte(8'hAB, 1, 0);
    put_byte(8'hCD, 0, 0);
    for (int i = 0; i < 2 * (DEPTH - 1); i++) put_byte(8'($urandom), 0, 0);

    phase = "load_b1";
    for (int i = 0; i < DEPTH; i++) begin
      put_byte(8'(i + 1), i == 0, 1);
      put_byte(8'h00, 0, 1);
    end
    put_byte(8'hFF, 0, 1);  // bank full: ignored
    phase = "load_b23";
    for (int b = 2; b < 4; b++)
      for (int i = 0; i < 2 * DEPTH; i++) put_byte(8'($urandom), i == 0, b);

    phase = "len0";
    play(0, 0, 0);
    repeat (3) tick();
    phase = "b1_len3";
    play(1, 3, 0);
    repeat (6) tick();
    phase = "full_b1";
    play(1, DEPTH - 1, 0);
    repeat (DEPTH + 2) tick();
    phase = "loop_abort";
    play(1, 1, 1);
    repeat (5) tick();
    start = 1; bank_sel = 2;
    tick();
    repeat (2) tick();
    abort = 1; start = 1;
    tick();
    repeat (3) tick();

    // Loading the bank being played is rejected word by word
    phase = "wr_err";
    play(1, DEPTH - 1, 1);
    for (int i = 0; i < 2 * DEPTH; i++) put_byte(8'($urandom), i == 0, 1);
    phase = "conc_load_b2";
    for (int i = 0; i < 2 * DEPTH; i++) put_byte(8'($urandom), i == 0, 2);
    abort = 1;
    tick();
    phase = "verify_b1";
    play(1, DEPTH - 1, 0);
    repeat (DEPTH + 1) tick();
    phase = "verify_b2";
    play(2, DEPTH - 1, 0);
    repeat (DEPTH + 1) tick();

    phase = "mid_reset";
    play(1, DEPTH - 1, 0);
    repeat (4) tick();
    put_byte(8'h5A, 1, 3);
    rst_n = 0;
    tick();
    rst_n = 1;
    wr = 1; dato = 8'h77;  // no ld_start: loader is idle after reset
    tick();
    for (int i = 0; i < 2 * DEPTH; i++) put_byte(8'($urandom), i == 0, 3);
    play(3, DEPTH - 1, 0);
    repeat (DEPTH + 1) tick();

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      start    = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 31) == 0);
      bank_sel = 2'($urandom);
      len      = 5'($urandom);
      loop_en  = ($urandom_range(0, 3) == 0);
      ld_start = ($urandom_range(0, 39) == 0);
      ld_bank  = 2'($urandom);
      wr       = $urandom_range(0, 1) == 1;
      dato     = 8'($urandom);
      rst_n    = ($urandom_range(0, 299) != 0);
      tick();
      rst_n = 1;
    end
    phase = "drain";
    abort = 1;
    tick();
    repeat (3) tick();
    @(negedge clk);
    #1;
    finished = 1;
    if (exp_q.size() != 0 || n_fail != 0) begin
      $display("FAIL final: %0d expectations undrained, %0d mismatches", exp_q.size(), n_fail);
    end else begin
      $display("PASS");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/secuenciador_param.md
SECUENCIADOR_PARAM -- requirements
Module: secuenciador_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16: pattern word width in bits, a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 32: words per bank, a power of 2, minimum 4; AW = log2(DEPTH).
REQ-003 SHALL have parameter NBANKS, default 4: number of pattern banks, minimum 2; BW = max(1, log2(NBANKS)).
REQ-004 SHALL have parameter IDLE_WORD, default 0: value driven on the output while not playing.
REQ-005 clk  in  1  sole clock; all logic is rising-edge.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 start  in  1  one-cycle pulse that begins playback.
REQ-008 abort  in  1  stops playback at the next edge.
REQ-009 bank_sel  in  BW  playback bank, sampled on start.
REQ-010 len  in  AW  last playback index (words played = len+1), sampled on start.
REQ-011 loop_en  in  1  replay continuously, sampled on start.
REQ-012 ld_start  in  1  resets the load pointer for bank ld_bank.
REQ-013 ld_bank  in  BW  load target bank, sampled on ld_start.
REQ-014 wr  in  1  byte strobe.
REQ-015 dato  in  8  load byte; words are assembled LSB byte first.
REQ-016 theBeanConfig  out  WIDTH  registered pattern output.
REQ-017 busy  out  1  high in RUN state.
REQ-018 done  out  1  one-cycle pulse at normal (non-looped) completion.
REQ-019 wr_err  out  1  one-cycle pulse when a completed word is rejected.

Function
REQ-020 Playback FSM SHALL have states IDLE and RUN; it SHALL leave reset in IDLE.
REQ-021 IDLE: theBeanConfig = IDLE_WORD, busy = 0.
REQ-022 IDLE + start: latch bank_sel, len and loop_en, go to RUN, read index 0; theBeanConfig = mem[bank][0] on the edge after start, so latency is 1 cycle.
REQ-023 RUN: output index i advances by 1 per clock; after index len the next edge SHALL show index 0 if loop_en is latched, else IDLE_WORD with done = 1 in that same cycle.
REQ-024 len = 0 SHALL play exactly one word; len = DEPTH-1 SHALL play the full bank with no index wrap error.
REQ-025 start in RUN SHALL be ignored.
REQ-026 abort has priority over start and over completion: the next edge SHALL show IDLE, IDLE_WORD, busy = 0, done = 0.
REQ-027 Loader SHALL hold a byte counter (0..WIDTH/8-1), a word pointer (AW+1 bits), a target bank and a word assembly register.
REQ-028 ld_start SHALL clear the byte counter and word pointer and latch ld_bank; a wr in the same cycle SHALL be taken as byte 0 of word 0.
REQ-029 Each wr SHALL place dato into byte lane [byte counter]; on the final byte the assembled word SHALL be written to mem[ld_bank][pointer], the pointer SHALL increment and the byte counter SHALL clear.
REQ-030 Once the pointer reaches DEPTH the bank is full: further wr SHALL be ignored, with no wrap and no wr_err.
REQ-031 A completed word targeting the bank latched by a RUN in progress SHALL NOT be written; wr_err SHALL pulse, and the pointer SHALL still increment.
REQ-032 Loading and playback of different banks SHALL proceed concurrently without interference.
REQ-033 Memory contents SHALL NOT be cleared by reset (initial content undefined; the bench preloads through the loader).

Reset
REQ-034 While rst_n = 0 at an edge: FSM to IDLE, theBeanConfig = IDLE_WORD, busy = 0, done = 0, wr_err = 0, byte counter = 0, word pointer = DEPTH (loader idle/full), loaded bank = 0.
REQ-035 Reset SHALL take priority over all inputs, including mid-playback and mid-word load, and any partial word SHALL be discarded.

Verification
REQ-036 Defaults. Load bank 1 with 0x0001..0x0020 (64 bytes) -> memory holds these words, the pointer is saturated, and a 65th byte changes nothing.
REQ-037 Defaults. start with bank 1, len = 3, loop_en = 0 -> outputs 0x0001, 0x0002, 0x0003, 0x0004 on cycles +1..+4; cycle +5 shows 0x0000 with done = 1; busy is high on cycles +1..+4.
REQ-038 Same setup with loop_en = 1 and len = 1 -> outputs 1,2,1,2,...; abort -> next cycle 0x0000, done = 0.
REQ-039 Play bank 1 with len = 31 while loading bank 1 -> wr_err pulses once per completed word and bank 1 is unchanged; loading bank 2 at the same time succeeds.
REQ-040 Apply rst_n = 0 during RUN index 5 and mid-word (1 byte loaded) -> next edge shows IDLE_WORD with busy = 0; a fresh load starts at byte 0 with no corrupted word.
REQ-041 Set ld_start and wr in the same cycle with dato = 0xAB, then wr 0xCD -> word 0 = 0xCDAB.
